// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory bus arbiter: FSM state
// encoding and requester identifiers.
package mem_arbiter_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_BUS_I  = 3'd1,
    S_BUS_D  = 3'd2,
    S_DONE_I = 3'd3,
    S_DONE_D = 3'd4
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/done signals and the single-port memory bus, bundled
// so the arbiter and its environment share one declaration.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Handshakes: a requester raises xreq and holds it (with its address/data)
  // until xdone pulses; the arbiter raises mem_req and holds it with stable
  // bus outputs until a cycle where mem_req & mem_ack, which completes it.
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic          iabort;
  logic [DW-1:0] irdata;
  logic          idone;
  logic          istall;

  logic            dreq;
  logic            dwe;
  logic [DW/8-1:0] dsel;
  logic [AW-1:0]   daddr;
  logic [DW-1:0]   dwdata;
  logic [DW-1:0]   drdata;
  logic            ddone;
  logic            dstall;

  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_sel;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;

  modport master (
    input  ireq, iaddr, iabort, dreq, dwe, dsel, daddr, dwdata,
           mem_rdata, mem_ack,
    output irdata, idone, istall, drdata, ddone, dstall,
           mem_req, mem_we, mem_sel, mem_addr, mem_wdata
  );

  modport slave (
    output ireq, iaddr, iabort, dreq, dwe, dsel, daddr, dwdata,
           mem_rdata, mem_ack,
    input  irdata, idone, istall, drdata, ddone, dstall,
           mem_req, mem_we, mem_sel, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and
// load/store, data first with a bounded run of data grants while fetch waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_DRUN = 4,
  parameter int DRUN_W   = $clog2(MAX_DRUN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.master     bus,
  output state_t            o_state,
  output logic [DRUN_W-1:0] o_drun,
  output logic              o_abort
);

  localparam logic [DW/8-1:0] SEL_ALL = '1;

  state_t            r_state, w_next;
  logic [DRUN_W-1:0] r_drun;
  logic              r_abort;
  logic              r_mem_req, r_mem_we;
  logic [DW/8-1:0]   r_mem_sel;
  logic [AW-1:0]     r_mem_addr;
  logic [DW-1:0]     r_mem_wdata, r_irdata, r_drdata;

  logic w_arb_slot, w_drun_max, w_ireq_eff, w_dreq_eff;
  logic w_grant_i, w_grant_d, w_ack, w_abort_now;

  // In DONE_x the requester's req still reflects the access just finished.
  always_comb begin
    w_arb_slot  = (r_state == S_IDLE) || (r_state == S_DONE_I) || (r_state == S_DONE_D);
    w_drun_max  = (r_drun == DRUN_W'(MAX_DRUN));
    w_ireq_eff  = w_arb_slot && bus.ireq && !bus.iabort && (r_state != S_DONE_I);
    w_dreq_eff  = w_arb_slot && bus.dreq && (r_state != S_DONE_D);
    w_grant_d   = w_dreq_eff && !(w_ireq_eff && w_drun_max);
    w_grant_i   = w_ireq_eff && !w_grant_d;
    w_ack       = r_mem_req && bus.mem_ack;
    w_abort_now = r_abort || bus.iabort;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE_I, S_DONE_D: begin
        if (w_grant_d)      w_next = S_BUS_D;
        else if (w_grant_i) w_next = S_BUS_I;
        else                w_next = S_IDLE;
      end
      S_BUS_I: if (w_ack) w_next = w_abort_now ? S_IDLE : S_DONE_I;
      S_BUS_D: if (w_ack) w_next = S_DONE_D;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drun      <= '0;
      r_abort     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_sel   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_irdata    <= '0;
      r_drdata    <= '0;
    end else begin
      r_state <= w_next;

      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.dwe;
        r_mem_sel   <= bus.dsel;
        r_mem_addr  <= bus.daddr;
        r_mem_wdata <= bus.dwdata;
      end else if (w_grant_i) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_sel   <= SEL_ALL;
        r_mem_addr  <= bus.iaddr;
        r_mem_wdata <= '0;
      end else if (w_ack) begin
        r_mem_req <= 1'b0;
      end

      if (w_ack && (r_state == S_BUS_D) && !r_mem_we) r_drdata <= bus.mem_rdata;
      if (w_ack && (r_state == S_BUS_I) && !w_abort_now) r_irdata <= bus.mem_rdata;

      // An abort seen at any point of the fetch bus cycle discards its data.
      if (r_state == S_BUS_I) r_abort <= w_ack ? 1'b0 : w_abort_now;
      else                    r_abort <= 1'b0;

      if (!bus.ireq || w_grant_i)       r_drun <= '0;
      else if (w_grant_d && !w_drun_max) r_drun <= r_drun + DRUN_W'(1);
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_sel   = r_mem_sel;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.irdata    = r_irdata;
  assign bus.drdata    = r_drdata;
  assign bus.idone     = (r_state == S_DONE_I);
  assign bus.ddone     = (r_state == S_DONE_D);
  assign bus.istall    = bus.ireq && (r_state != S_DONE_I);
  assign bus.dstall    = bus.dreq && (r_state != S_DONE_D);

  assign o_state = r_state;
  assign o_drun  = r_drun;
  assign o_abort = r_abort;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario with hand-computed
// cycle-by-cycle expectations and a memory responder of configurable latency.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  state_t      dut_state;
  logic [2:0]  dut_drun;
  logic        dut_abort;

  int          errors = 0;
  int          checks = 0;
  int          ack_lat = 0;
  int          req_cyc = 0;
  logic [31:0] mem_data = '0;

  localparam logic [31:0] VAL_F0 = 32'h1234_5678;
  localparam logic [31:0] VAL_A  = 32'hAAAA_0001;
  localparam logic [31:0] VAL_B  = 32'hBBBB_0002;
  localparam logic [31:0] VAL_C  = 32'hCCCC_0003;
  localparam logic [31:0] VAL_E  = 32'hEEEE_0004;
  localparam logic [31:0] VAL_L  = 32'h0000_5A5A;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .MAX_DRUN(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .o_state (dut_state),
    .o_drun  (dut_drun),
    .o_abort (dut_abort)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // memory responder: ack in the (ack_lat+1)-th cycle that mem_req is high
  always @(posedge clk) begin
    #1;
    if (bus.mem_req) begin
      bus.mem_ack   = (req_cyc == ack_lat);
      bus.mem_rdata = mem_data;
      req_cyc++;
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      req_cyc = 0;
    end
  end

  // lands 2 time units into the next cycle, after the responder settles
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (dut_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut_state, S_IDLE); end
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_sel} !== 6'b0) begin errors++; $display("FAIL reset_mem_ctl: got %b want 0", {bus.mem_req, bus.mem_we, bus.mem_sel}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== 64'b0) begin errors++; $display("FAIL reset_mem_data: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
    checks++; if ({bus.irdata, bus.drdata} !== 64'b0) begin errors++; $display("FAIL reset_rdata: got %h want 0", {bus.irdata, bus.drdata}); end
    checks++; if ({bus.idone, bus.ddone, dut_drun, dut_abort} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 0", {bus.idone, bus.ddone, dut_drun, dut_abort}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    ack_lat = 0; mem_data = VAL_F0;
    bus.ireq = 1'b1; bus.iaddr = 32'h0000_0100;
    #1;
    checks++; if (bus.istall !== 1'b1) begin errors++; $display("FAIL fetch_istall_c0: got %b want 1", bus.istall); end
    tick(); #1;
    checks++; if (dut_state !== S_BUS_I) begin errors++; $display("FAIL fetch_state_c1: got %0d want %0d", dut_state, S_BUS_I); end
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_sel} !== 6'b1_0_1111) begin errors++; $display("FAIL fetch_bus_ctl_c1: got %b want 101111", {bus.mem_req, bus.mem_we, bus.mem_sel}); end
    checks++; if (bus.mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL fetch_addr_c1: got %h want 00000100", bus.mem_addr); end
    tick(); #1;
    checks++; if ({bus.idone, bus.istall, bus.mem_req} !== 3'b100) begin errors++; $display("FAIL fetch_done_c2: got %b want 100", {bus.idone, bus.istall, bus.mem_req}); end
    checks++; if (bus.irdata !== VAL_F0) begin errors++; $display("FAIL fetch_irdata_c2: got %h want %h", bus.irdata, VAL_F0); end
    bus.ireq = 1'b0;
    tick(); #1;
    checks++; if ({bus.idone, dut_state} !== {1'b0, S_IDLE}) begin errors++; $display("FAIL fetch_idle_c3: got %b want 0000", {bus.idone, dut_state}); end
  endtask

  task automatic test_both_latency2();
    ack_lat = 1; mem_data = VAL_A;
    bus.ireq = 1'b1; bus.iaddr = 32'h0000_0200;
    bus.dreq = 1'b1; bus.dwe = 1'b0; bus.dsel = 4'hF; bus.daddr = 32'h0000_0300;
    tick(); #1;
    checks++; if ({dut_state, dut_drun} !== {S_BUS_D, 3'd1}) begin errors++; $display("FAIL both_c1: got state %0d drun %0d want 2/1", dut_state, dut_drun); end
    checks++; if (bus.mem_addr !== 32'h0000_0300) begin errors++; $display("FAIL both_daddr_c1: got %h want 00000300", bus.mem_addr); end
    tick(); #1;
    checks++; if ({bus.ddone, bus.mem_req} !== 2'b01) begin errors++; $display("FAIL both_wait_c2: got %b want 01", {bus.ddone, bus.mem_req}); end
    tick(); #1;
    checks++; if ({bus.ddone, bus.dstall, bus.istall} !== 3'b101) begin errors++; $display("FAIL both_ddone_c3: got %b want 101", {bus.ddone, bus.dstall, bus.istall}); end
    checks++; if (bus.drdata !== VAL_A) begin errors++; $display("FAIL both_drdata_c3: got %h want %h", bus.drdata, VAL_A); end
    bus.dreq = 1'b0; mem_data = VAL_B;
    tick(); #1;
    checks++; if ({dut_state, dut_drun} !== {S_BUS_I, 3'd0}) begin errors++; $display("FAIL both_c4: got state %0d drun %0d want 1/0", dut_state, dut_drun); end
    checks++; if (bus.mem_addr !== 32'h0000_0200) begin errors++; $display("FAIL both_iaddr_c4: got %h want 00000200", bus.mem_addr); end
    tick(); #1;
    checks++; if (bus.idone !== 1'b0) begin errors++; $display("FAIL both_no_idone_c5: got %b want 0", bus.idone); end
    tick(); #1;
    checks++; if ({bus.idone, bus.irdata} !== {1'b1, VAL_B}) begin errors++; $display("FAIL both_idone_c6: got %b/%h want 1/%h", bus.idone, bus.irdata, VAL_B); end
    bus.ireq = 1'b0;
    tick();
  endtask

  task automatic test_drun_starvation();
    ack_lat = 0; mem_data = VAL_C;
    bus.ireq = 1'b1; bus.iaddr = 32'h0000_0400;
    bus.dreq = 1'b1; bus.dwe = 1'b1; bus.dsel = 4'hF;
    for (int k = 0; k < 4; k++) begin
      bus.iabort = 1'b0;
      bus.daddr  = 32'h0000_0500 + 32'(4 * k);
      bus.dwdata = 32'hD000_0000 + 32'(k);
      #1;
      checks++; if ({dut_state, dut_drun} !== {S_IDLE, 3'(k)}) begin errors++; $display("FAIL drun_idle_%0d: got state %0d drun %0d want 0/%0d", k, dut_state, dut_drun, k); end
      tick(); #1;
      checks++; if ({bus.mem_we, bus.mem_wdata} !== {1'b1, 32'hD000_0000 + 32'(k)}) begin errors++; $display("FAIL drun_store_%0d: got %b/%h want 1/%h", k, bus.mem_we, bus.mem_wdata, 32'hD000_0000 + 32'(k)); end
      tick(); #1;
      checks++; if ({bus.ddone, bus.istall, bus.drdata} !== {2'b11, VAL_A}) begin errors++; $display("FAIL drun_ddone_%0d: got %b%b/%h want 11/%h", k, bus.ddone, bus.istall, bus.drdata, VAL_A); end
      // hold off the waiting fetch so the next store is granted from IDLE
      bus.iabort = 1'b1;
      tick();
    end
    bus.iabort = 1'b0;
    bus.daddr = 32'h0000_0510; bus.dwdata = 32'hD000_0004;
    #1;
    checks++; if ({dut_state, dut_drun} !== {S_IDLE, 3'd4}) begin errors++; $display("FAIL drun_sat: got state %0d drun %0d want 0/4", dut_state, dut_drun); end
    tick(); #1;
    checks++; if ({dut_state, dut_drun, bus.mem_we} !== {S_BUS_I, 3'd0, 1'b0}) begin errors++; $display("FAIL drun_fetch_wins: got state %0d drun %0d we %b want 1/0/0", dut_state, dut_drun, bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h0000_0400) begin errors++; $display("FAIL drun_fetch_addr: got %h want 00000400", bus.mem_addr); end
    tick(); #1;
    checks++; if ({bus.idone, bus.irdata} !== {1'b1, VAL_C}) begin errors++; $display("FAIL drun_idone: got %b/%h want 1/%h", bus.idone, bus.irdata, VAL_C); end
    bus.ireq = 1'b0;
    tick(); #1;
    checks++; if ({dut_state, dut_drun, bus.mem_wdata} !== {S_BUS_D, 3'd0, 32'hD000_0004}) begin errors++; $display("FAIL drun_fifth_store: got state %0d drun %0d wdata %h want 2/0/d0000004", dut_state, dut_drun, bus.mem_wdata); end
    tick(); #1;
    checks++; if ({bus.ddone, bus.drdata} !== {1'b1, VAL_A}) begin errors++; $display("FAIL drun_store_no_capture: got %b/%h want 1/%h", bus.ddone, bus.drdata, VAL_A); end
    bus.dreq = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    ack_lat = 1; mem_data = VAL_E;
    bus.ireq = 1'b1; bus.iaddr = 32'h0000_0600;
    tick(); #1;
    checks++; if (dut_state !== S_BUS_I) begin errors++; $display("FAIL abort_bus_i: got %0d want %0d", dut_state, S_BUS_I); end
    bus.iabort = 1'b1;
    tick();
    bus.iabort = 1'b0; bus.ireq = 1'b0;
    #1;
    checks++; if ({dut_abort, bus.mem_req, bus.mem_ack} !== 3'b111) begin errors++; $display("FAIL abort_flag: got %b want 111", {dut_abort, bus.mem_req, bus.mem_ack}); end
    tick(); #1;
    checks++; if ({dut_state, bus.idone, dut_abort} !== {S_IDLE, 2'b00}) begin errors++; $display("FAIL abort_idle: got state %0d idone %b abort %b want 0/0/0", dut_state, bus.idone, dut_abort); end
    checks++; if (bus.irdata !== VAL_C) begin errors++; $display("FAIL abort_irdata_kept: got %h want %h", bus.irdata, VAL_C); end
    tick();
  endtask

  task automatic test_load_sel();
    ack_lat = 0; mem_data = VAL_L;
    bus.dreq = 1'b1; bus.dwe = 1'b0; bus.dsel = 4'b0011; bus.daddr = 32'h0000_0800;
    #1;
    checks++; if (bus.dstall !== 1'b1) begin errors++; $display("FAIL load_dstall_c0: got %b want 1", bus.dstall); end
    tick(); #1;
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_sel} !== 6'b1_0_0011) begin errors++; $display("FAIL load_bus_ctl: got %b want 100011", {bus.mem_req, bus.mem_we, bus.mem_sel}); end
    tick(); #1;
    checks++; if ({bus.ddone, bus.dstall, bus.drdata} !== {2'b10, VAL_L}) begin errors++; $display("FAIL load_done: got %b%b/%h want 10/%h", bus.ddone, bus.dstall, bus.drdata, VAL_L); end
    bus.dreq = 1'b0;
    tick(); #1;
    checks++; if ({bus.ddone, bus.dstall, dut_state} !== {2'b00, S_IDLE}) begin errors++; $display("FAIL load_after: got %b%b state %0d want 00/0", bus.ddone, bus.dstall, dut_state); end
  endtask

  task automatic test_reset_in_bus();
    ack_lat = 100;
    bus.dreq = 1'b1; bus.dwe = 1'b0; bus.dsel = 4'hF; bus.daddr = 32'h0000_0700;
    tick(); #1;
    checks++; if ({dut_state, bus.mem_req} !== {S_BUS_D, 1'b1}) begin errors++; $display("FAIL rstbus_busd: got state %0d req %b want 2/1", dut_state, bus.mem_req); end
    rst = 1'b1;
    tick(); #1;
    checks++; if ({dut_state, bus.mem_req, bus.mem_we, bus.mem_sel, bus.idone, bus.ddone} !== {S_IDLE, 8'b0}) begin errors++; $display("FAIL rstbus_ctl: got state %0d req %b want 0/0", dut_state, bus.mem_req); end
    checks++; if ({bus.mem_addr, bus.irdata, bus.drdata} !== 96'b0) begin errors++; $display("FAIL rstbus_data: got %h/%h/%h want 0", bus.mem_addr, bus.irdata, bus.drdata); end
    rst = 1'b0; bus.dreq = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.ireq = 1'b0; bus.iaddr = '0; bus.iabort = 1'b0;
    bus.dreq = 1'b0; bus.dwe = 1'b0; bus.dsel = '0; bus.daddr = '0; bus.dwdata = '0;
    test_reset();
    test_fetch_only();
    test_both_latency2();
    test_drun_starvation();
    test_abort();
    test_load_sel();
    test_reset_in_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
